// File: rtl/pattern_detect_param_if.sv
// Bus bundle for pattern_detect_param.
// The master side drives configuration, the serial stream and the counter clear.
// The slave side (the detector) returns the match pulse, the match count and the history fill.
interface pattern_detect_param_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
);
   logic               in_cfg_we;
   logic [MAX_LEN-1:0] in_cfg_pat;
   logic [LEN_W-1:0]   in_cfg_len;
   logic               in_cfg_ovl;
   logic               in_valid;
   logic               in_p;
   logic               in_clr;
   logic               o_d;
   logic [CNT_W-1:0]   o_cnt;
   logic [LEN_W-1:0]   o_fill;

   modport master (
      output in_cfg_we, in_cfg_pat, in_cfg_len, in_cfg_ovl, in_valid, in_p, in_clr,
      input  o_d, o_cnt, o_fill
   );

   modport slave (
      input  in_cfg_we, in_cfg_pat, in_cfg_len, in_cfg_ovl, in_valid, in_p, in_clr,
      output o_d, o_cnt, o_fill
   );
endinterface

// File: rtl/pattern_detect_param.sv
// Serial pattern detector with a runtime-programmable pattern, length and overlap mode.
// bit 0 of the pattern is the newest bit. A match raises a one-cycle registered pulse
// and bumps a saturating counter. Out of reset the block detects "101" with overlap.
module pattern_detect_param #(
   parameter int                 MAX_LEN = 8,
   parameter int                 LEN_W   = 4,
   parameter int                 CNT_W   = 8,
   parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(3'b101),
   parameter int                 DEF_LEN = 3
) (
   input  logic                    in_clk,
   input  logic                    in_rst,
   pattern_detect_param_if.slave   bus
);

   localparam logic [LEN_W:0]   MAX_LEN_X = (LEN_W+1)'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

   logic [MAX_LEN-1:0] pat_r;
   logic [LEN_W-1:0]   len_r;
   logic               ovl_r;

   // Only MAX_LEN-1 old bits are kept; the incoming bit completes the candidate window.
   logic [MAX_LEN-2:0] hist_r;
   logic [LEN_W-1:0]   fill_r;
   logic               d_r;
   logic [CNT_W-1:0]   cnt_r;

   logic [MAX_LEN-1:0] cand;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W-1:0]   cfg_len_clamped;
   logic [LEN_W:0]     fill_inc;
   logic               fill_ok;
   logic               pat_hit;
   logic               sample;
   logic               match;
   logic [LEN_W-1:0]   fill_sat;

   assign cand = {hist_r, bus.in_p};

   // Compare only the low len bits of the candidate against the pattern.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < len_r);
      end
   end

   // Lengths 0 and 1 both mean a single-bit pattern; oversize lengths clamp to MAX_LEN.
   always_comb begin
      cfg_len_clamped = bus.in_cfg_len;
      if (bus.in_cfg_len <= LEN_ONE) begin
         cfg_len_clamped = LEN_ONE;
      end else if ({1'b0, bus.in_cfg_len} > MAX_LEN_X) begin
         cfg_len_clamped = MAX_LEN_X[LEN_W-1:0];
      end
   end

   assign pat_hit  = (((cand ^ pat_r) & len_mask) == '0);
   assign fill_inc = {1'b0, fill_r} + (LEN_W+1)'(1);
   assign fill_ok  = (fill_inc >= {1'b0, len_r});
   assign sample   = bus.in_valid & ~bus.in_cfg_we;
   assign match    = sample & fill_ok & pat_hit;
   assign fill_sat = fill_ok ? len_r : fill_inc[LEN_W-1:0];

   // Configuration registers, loaded by the write strobe.
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         pat_r <= DEF_PAT;
         len_r <= LEN_W'(DEF_LEN);
         ovl_r <= 1'b1;
      end else if (bus.in_cfg_we) begin
         pat_r <= bus.in_cfg_pat;
         len_r <= cfg_len_clamped;
         ovl_r <= bus.in_cfg_ovl;
      end
   end

   // History shift and fill tracking; a config write restarts detection from scratch.
   // In non-overlap mode a match zeroes fill, which alone blocks reuse of the old bits.
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         hist_r <= '0;
         fill_r <= '0;
      end else if (bus.in_cfg_we) begin
         hist_r <= '0;
         fill_r <= '0;
      end else if (bus.in_valid) begin
         hist_r <= cand[MAX_LEN-2:0];
         fill_r <= (match && !ovl_r) ? '0 : fill_sat;
      end
   end

   // Registered one-cycle match pulse.
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         d_r <= 1'b0;
      end else begin
         d_r <= match;
      end
   end

   // Saturating match counter; clear wins over a simultaneous increment.
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         cnt_r <= '0;
      end else if (bus.in_clr) begin
         cnt_r <= '0;
      end else if (match && !(&cnt_r)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign bus.o_d    = d_r;
   assign bus.o_cnt  = cnt_r;
   assign bus.o_fill = fill_r;

endmodule

// File: tb/tb_pattern_detect_param.sv
// Directed bench for pattern_detect_param with a 4-bit counter so saturation is reachable.
// Expected pulses are queued as each bit is driven and popped once the edge has passed.
module tb_pattern_detect_param;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 4;

   logic in_clk = 1'b0;
   logic in_rst = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int n_step  = 0;

   logic sb_q[$];

   pattern_detect_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

   pattern_detect_param #(
      .MAX_LEN(MAX_LEN),
      .LEN_W  (LEN_W),
      .CNT_W  (CNT_W)
   ) dut (
      .in_clk(in_clk),
      .in_rst(in_rst),
      .bus   (bus.slave)
   );

   always #5 in_clk = ~in_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.in_cfg_we  = 1'b0;
      bus.in_cfg_pat = '0;
      bus.in_cfg_len = '0;
      bus.in_cfg_ovl = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_p       = 1'b0;
      bus.in_clr     = 1'b0;
   endtask

   task automatic cyc(input logic we, input logic [7:0] pat, input logic [3:0] len,
                      input logic ovl, input logic v, input logic b, input logic clr,
                      input logic exp_d);
      logic e;
      @(negedge in_clk);
      bus.in_cfg_we  = we;
      bus.in_cfg_pat = pat;
      bus.in_cfg_len = len;
      bus.in_cfg_ovl = ovl;
      bus.in_valid   = v;
      bus.in_p       = b;
      bus.in_clr     = clr;
      sb_q.push_back(exp_d);
      @(posedge in_clk);
      #1;
      e = sb_q.pop_front();
      n_step++;
      chk($sformatf("o_d step %0d", n_step), 32'(bus.o_d), 32'(e));
      idle_inputs();
   endtask

   task automatic bit_in(input logic b, input logic exp_d);
      cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, 1'b0, exp_d);
   endtask

   task automatic gap();
      cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wcfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                       input logic clr);
      cyc(1'b1, pat, len, ovl, 1'b0, 1'b0, clr, 1'b0);
   endtask

   initial begin
      idle_inputs();

      // reset state
      repeat (2) @(negedge in_clk);
      chk("rst o_d", 32'(bus.o_d), 32'd0);
      chk("rst o_cnt", 32'(bus.o_cnt), 32'd0);
      chk("rst o_fill", 32'(bus.o_fill), 32'd0);
      in_rst = 1'b1;

      // default 101 overlapping
      bit_in(1, 0); bit_in(0, 0); bit_in(1, 1); bit_in(0, 0); bit_in(1, 1);
      chk("def o_cnt", 32'(bus.o_cnt), 32'd2);
      chk("def o_fill", 32'(bus.o_fill), 32'd3);

      // non-overlap 101; config write keeps the count
      wcfg(8'b101, 4'd3, 1'b0, 1'b0);
      chk("cfg keeps o_cnt", 32'(bus.o_cnt), 32'd2);
      chk("cfg clears o_fill", 32'(bus.o_fill), 32'd0);
      cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("clr o_cnt", 32'(bus.o_cnt), 32'd0);
      bit_in(1, 0); bit_in(0, 0); bit_in(1, 1); bit_in(0, 0); bit_in(1, 0);
      chk("novl o_cnt", 32'(bus.o_cnt), 32'd1);
      chk("novl o_fill", 32'(bus.o_fill), 32'd2);

      // length 4, pattern 1101 overlapping
      wcfg(8'b1101, 4'd4, 1'b1, 1'b0);
      bit_in(1, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 1);
      bit_in(1, 0); bit_in(0, 0); bit_in(1, 1);
      chk("len4 o_cnt", 32'(bus.o_cnt), 32'd3);
      chk("len4 o_fill", 32'(bus.o_fill), 32'd4);

      // same with valid gaps between bits 5 and 6
      wcfg(8'b1101, 4'd4, 1'b1, 1'b0);
      bit_in(1, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 1); bit_in(1, 0);
      gap(); gap(); gap();
      chk("gap o_fill", 32'(bus.o_fill), 32'd4);
      chk("gap o_cnt", 32'(bus.o_cnt), 32'd4);
      bit_in(0, 0); bit_in(1, 1);
      chk("gap2 o_cnt", 32'(bus.o_cnt), 32'd5);

      // len 0 clamps to 1; counter saturates at 15
      wcfg(8'h01, 4'd0, 1'b1, 1'b1);
      chk("cfg+clr o_cnt", 32'(bus.o_cnt), 32'd0);
      for (int i = 0; i < 15; i++) bit_in(1, 1);
      chk("sat15 o_cnt", 32'(bus.o_cnt), 32'd15);
      for (int i = 0; i < 5; i++) bit_in(1, 1);
      chk("sat20 o_cnt", 32'(bus.o_cnt), 32'd15);
      chk("len1 o_fill", 32'(bus.o_fill), 32'd1);
      cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("clr+match o_cnt", 32'(bus.o_cnt), 32'd0);

      // oversize length clamps to MAX_LEN
      wcfg(8'hA5, 4'd15, 1'b1, 1'b0);
      bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(0, 0);
      bit_in(0, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 1);
      chk("len8 o_cnt", 32'(bus.o_cnt), 32'd1);
      chk("len8 o_fill", 32'(bus.o_fill), 32'd8);

      // config write on the completing edge suppresses the match
      wcfg(8'b110, 4'd3, 1'b0, 1'b0);
      bit_in(1, 0); bit_in(1, 0);
      cyc(1'b1, 8'b110, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("coll o_fill", 32'(bus.o_fill), 32'd0);
      chk("coll o_cnt", 32'(bus.o_cnt), 32'd1);
      bit_in(1, 0); bit_in(1, 0); bit_in(0, 1);
      chk("110 o_cnt", 32'(bus.o_cnt), 32'd2);
      chk("110 novl o_fill", 32'(bus.o_fill), 32'd0);
      bit_in(1, 0); bit_in(1, 0); bit_in(0, 1);
      chk("110b o_fill", 32'(bus.o_fill), 32'd0);

      // asynchronous reset while the pulse is high
      #2 in_rst = 1'b0;
      #1;
      chk("arst o_d", 32'(bus.o_d), 32'd0);
      chk("arst o_cnt", 32'(bus.o_cnt), 32'd0);
      chk("arst o_fill", 32'(bus.o_fill), 32'd0);
      @(negedge in_clk);
      in_rst = 1'b1;

      // defaults restored: 101 overlapping
      bit_in(1, 0); bit_in(0, 0); bit_in(1, 1); bit_in(0, 0); bit_in(1, 1);
      chk("post-rst o_cnt", 32'(bus.o_cnt), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_detect_param.md
# pattern_detect_param

Parametrised serial pattern detector: watches a 1-bit input stream qualified by a valid strobe and raises a one-cycle flag whenever the most recent `len` bits equal a runtime-programmable pattern. Pattern, length and overlap mode are loaded through a configuration port. A saturating match counter is exposed. Out of reset, the block behaves as a "101" overlapping detector, so it can replace fixed single-pattern detectors in the pattern-detect area.

## Interface
- `MAX_LEN`, default 8: maximum pattern length in bits, ≥ 2.
- `LEN_W`, default 4: width of the length field; must hold `MAX_LEN`.
- `CNT_W`, default 8: width of the match counter.
- `DEF_PAT`, default 'b101: pattern loaded at reset, zero-extended to `MAX_LEN`.
- `DEF_LEN`, default 3: length loaded at reset.
- `in_clk`, in, 1: single clock; all state changes on the rising edge.
- `in_rst`, in, 1: asynchronous, active-low reset.
- `in_cfg_we`, in, 1: configuration write strobe.
- `in_cfg_pat`, in, `MAX_LEN`: pattern; bit 0 is the newest bit, bit `len-1` is the oldest.
- `in_cfg_len`, in, `LEN_W`: pattern length.
- `in_cfg_ovl`, in, 1: 1 = overlapping matches allowed; 0 = history cleared after each match.
- `in_valid`, in, 1: `in_p` is sampled only when this is high.
- `in_p`, in, 1: serial data bit.
- `in_clr`, in, 1: synchronous clear of `o_cnt`.
- `o_d`, out, 1: registered one-cycle match pulse.
- `o_cnt`, out, `CNT_W`: saturating count of matches.
- `o_fill`, out, `LEN_W`: number of history bits currently valid, saturating at `len`.

## Operation
- **Configuration registers** (`pat`, `len`, `ovl`):
  - Reset values: `DEF_PAT`, `DEF_LEN`, 1.
  - Loaded when `in_cfg_we`=1.
  - `in_cfg_len`=0 or 1 loads 1; `in_cfg_len` > `MAX_LEN` loads `MAX_LEN`.
- **Config write side effects:** `in_cfg_we` clears the history and `fill`, and forces `o_d`=0 on that edge. It does not clear `o_cnt`.
- **Sampling:** when `in_valid`=1 and `in_cfg_we`=0:
  - cand = {hist[MAX_LEN-2:0], in_p}.
  - hist ← cand.
  - fill ← min(fill+1, len).
- **Match condition:** (fill+1 ≥ len) and (cand[len-1:0] == pat[len-1:0]), evaluated in the same sample.
- **On a match:**
  - o_d ← 1.
  - o_cnt ← o_cnt+1, holding at all-ones.
  - If ovl=0: fill ← 0 instead of the increment, so the next match needs `len` fresh bits. History bits are don't-care because `fill` gates matching.
- **No match:** when there is no match or `in_valid`=0, o_d ← 0.
- **Counter clear:**
  - `in_clr`=1 sets o_cnt ← 0 on that edge, overriding a simultaneous increment.
  - The `o_d` pulse still occurs.
- **Priority** (highest first): reset, then `in_cfg_we`, then sampling. `in_clr` is independent of `in_cfg_we`.
- **Idle:** `in_valid`=0 cycles freeze history, `fill` and `o_cnt`. Gaps do not break a match in progress.

## Timing
- **Reset** (`in_rst`=0, immediate, asynchronous): o_d=0, o_cnt=0, o_fill=0, history=0, config = defaults.
- **Latency:** a match on the bit sampled at edge N shows `o_d`=1 from edge N to edge N+1. Back-to-back matches in overlap mode with len=1 give consecutive high cycles.
- **`o_cnt`** updates on the same edge as `o_d`.
- **`o_fill`** reflects the post-edge value.
- **Config written at edge N:** the first bit counted under the new config is the one sampled at edge N+1.
- **Reset mid-stream:** a partial match is discarded; detection restarts with fill=0.

## Test plan
- **Reset defaults:** release reset, then stream 1,0,1,0,1 with valid held high → `o_d` pulses after bit 3 and after bit 5; `o_cnt`=2.
- **Non-overlap mode:** write pat='b101, len=3, ovl=0, then stream 1,0,1,0,1 → exactly one pulse (after bit 3); `o_cnt`=1; `o_fill`=2 at the end.
- **Reconfigure to length 4:** write pat='b1101, len=4, ovl=1, then stream 1,1,0,1,1,0,1 → pulses after bits 4 and 7. Insert valid=0 gaps between bits 5 and 6 and confirm the result is the same.
- **Clamping and saturation:** with CNT_W=4, write len=0 and pat=1, then stream 20 ones → `o_d` high for 20 consecutive cycles; `o_cnt` stops at 15. Assert `in_clr` together with a match → `o_cnt`=0.
- **Config and reset collisions:**
  - Assert `in_cfg_we` on the edge that would complete a match → no pulse; `o_fill`=0.
  - Drop `in_rst` asynchronously mid-pattern → `o_d`, `o_cnt` and `o_fill` read 0 immediately.
  - After release, the default "101" pattern is detected again from fresh bits.
